// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types, constants and width helpers for the instruction prefetch queue
package ifq_pkg;

    localparam int IFQ_IW = 32;
    localparam int IFQ_PW = 32;

    localparam logic [31:0] IFQ_NOP = 32'h0;

    typedef struct packed {
        logic [IFQ_PW-1:0] pc;
        logic [IFQ_IW-1:0] instr;
    } ifq_entry_t;

    // Occupancy must be able to represent DEPTH itself, not just DEPTH-1.
    function automatic int ifq_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - valid/ready handshake carrying an {instruction, pcStore} pair
interface ifetch_queue_if #(
    parameter int IW = 32,
    parameter int PW = 32
);
    logic          valid;
    logic          ready;
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;

    modport master (output valid, output instr, output pc, input ready);
    modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/ifq_ptr.sv
// rtl/ifq_ptr.sv - wrapping pointer register modulo DEPTH with increment and clear
module ifq_ptr #(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            clr,
    output logic [PTRW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTRW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch FIFO between fetch and the IF/ID wall; flush discards all entries
// Optional zero-latency empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int PW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    ifetch_queue_if.slave            in_if,
    ifetch_queue_if.master           out_if,
    output logic [ifq_cw(DEPTH)-1:0] count,
    output logic                     full,
    output logic                     empty
);

    localparam int CW   = ifq_cw(DEPTH);
    localparam int PTRW = $clog2(DEPTH);

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic            push;
    logic            pop;
    logic            byp_take;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign in_if.ready = ~full;

`ifdef IFQ_BYPASS_EN
    // An entry consumed straight through the bypass never touches storage.
    assign byp_take     = empty & in_if.valid & ~flush & out_if.ready;
    assign head         = empty ? entry_t'{pc: in_if.pc, instr: in_if.instr} : mem[rd_ptr];
    assign out_if.valid = ~flush & (~empty | in_if.valid);
`else
    assign byp_take     = 1'b0;
    assign head         = mem[rd_ptr];
    assign out_if.valid = ~flush & ~empty;
`endif

    assign push = in_if.valid & in_if.ready & ~flush & ~byp_take;
    assign pop  = out_if.valid & out_if.ready & ~flush & ~empty;

    assign out_if.instr = out_if.valid ? head.instr : IW'(IFQ_NOP);
    assign out_if.pc    = out_if.valid ? head.pc    : PW'(IFQ_NOP);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{pc: in_if.pc, instr: in_if.instr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    ifq_ptr #(.DEPTH(DEPTH), .PTRW(PTRW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    ifq_ptr #(.DEPTH(DEPTH), .PTRW(PTRW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;
    logic       full;
    logic       empty;
    int         vectors = 0;
    int         miscompares = 0;

    ifetch_queue_if #(.IW(32), .PW(32)) in_if ();
    ifetch_queue_if #(.IW(32), .PW(32)) out_if ();

    ifetch_queue #(.DEPTH(4), .IW(32), .PW(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .in_if  (in_if),
        .out_if (out_if),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a_instr [4];
    logic [31:0] b_in    [6];
    logic [31:0] b_out   [6];
    logic        b_rdy   [6];

    initial begin
        a_instr = '{32'h8C010004, 32'hA0000001, 32'hA0000002, 32'hA0000003};
        b_in    = '{32'hB0000000, 32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004};
        b_out   = '{32'h8C010004, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hB0000000, 32'hB0000001};
        b_rdy   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; flush = 1'b0;
        in_if.valid = 1'b0; in_if.instr = '0; in_if.pc = '0; out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("rst_out_instr", out_if.instr, 32'h0);
        chk("rst_out_pc", out_if.pc, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd1);
        rst_n = 1'b1;

        // single push, one-cycle latency (zero with bypass)
        cyc();
        in_if.valid = 1'b1; in_if.instr = 32'h8C010004; in_if.pc = 32'h8; out_if.ready = 1'b0;
        #1;
        chk("t1_same_cycle_valid", 32'(out_if.valid), BYP ? 32'd1 : 32'd0);
        cyc();
        in_if.valid = 1'b0;
        #1;
        chk("t1_out_valid", 32'(out_if.valid), 32'd1);
        chk("t1_out_instr", out_if.instr, 32'h8C010004);
        chk("t1_out_pc", out_if.pc, 32'h8);
        chk("t1_count", 32'(count), 32'd1);

        // fill to DEPTH, then a fifth entry is refused
        for (int i = 1; i < 4; i++) begin
            in_if.valid = 1'b1; in_if.instr = a_instr[i]; in_if.pc = 32'h10 + 32'(i);
            cyc();
        end
        in_if.instr = 32'hEEEE0004; in_if.pc = 32'h20;
        #1;
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_in_ready", 32'(in_if.ready), 32'd0);
        cyc();
        #1;
        chk("t2_count_held", 32'(count), 32'd4);
        chk("t2_head_kept", out_if.instr, 32'h8C010004);

        // drain while refilling; pointers wrap 3->0
        for (int k = 0; k < 6; k++) begin
            out_if.ready = 1'b1; in_if.valid = 1'b1; in_if.instr = b_in[k]; in_if.pc = 32'h40;
            #1;
            chk($sformatf("t3_pop_instr_%0d", k), out_if.instr, b_out[k]);
            chk($sformatf("t3_in_ready_%0d", k), 32'(in_if.ready), 32'(b_rdy[k]));
            cyc();
        end
        in_if.valid = 1'b0; out_if.ready = 1'b0;
        #1;
        chk("t3_count", 32'(count), 32'd3);
        chk("t3_head", out_if.instr, 32'hB0000002);

        // flush beats push and pop
        cyc();
        flush = 1'b1; in_if.valid = 1'b1; in_if.instr = 32'hDEADBEEF; in_if.pc = 32'h50; out_if.ready = 1'b1;
        #1;
        chk("t4_flush_valid", 32'(out_if.valid), 32'd0);
        chk("t4_flush_instr", out_if.instr, 32'h0);
        chk("t4_flush_pc", out_if.pc, 32'h0);
        cyc();
        flush = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b0;
        #1;
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_out_valid", 32'(out_if.valid), 32'd0);

        // empty queue with consumer ready
        cyc();
        in_if.valid = 1'b1; in_if.instr = 32'h20420001; in_if.pc = 32'h100; out_if.ready = 1'b1;
        #1;
        chk("t5_now_valid", 32'(out_if.valid), BYP ? 32'd1 : 32'd0);
        chk("t5_now_instr", out_if.instr, BYP ? 32'h20420001 : 32'h0);
        cyc();
        in_if.valid = 1'b0;
        #1;
        chk("t5_next_valid", 32'(out_if.valid), BYP ? 32'd0 : 32'd1);
        chk("t5_next_instr", out_if.instr, BYP ? 32'h0 : 32'h20420001);
        chk("t5_next_count", 32'(count), BYP ? 32'd0 : 32'd1);
        cyc();
        #1;
        chk("t5_drained", 32'(empty), 32'd1);

        // async reset mid-cycle with entries queued
        out_if.ready = 1'b0; in_if.valid = 1'b1; in_if.instr = 32'hC0000001; in_if.pc = 32'h200;
        cyc();
        in_if.instr = 32'hC0000002; in_if.pc = 32'h204;
        cyc();
        in_if.valid = 1'b0;
        #1;
        chk("t6_count_before", 32'(count), 32'd2);
        chk("t6_head_before", out_if.instr, 32'hC0000001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_if.valid), 32'd0);
        chk("t6_rst_instr", out_if.instr, 32'h0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_in_ready", 32'(in_if.ready), 32'd1);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
